// File: rtl/aud_trace_packer.sv
// AUD branch-trace packer: synchronises the receiver's oe strobe, queues trace entries and
// serialises them as byte frames. Optional timestamp field: define AUD_PKT_TIMESTAMP_EN.
module aud_trace_packer #(
    parameter int FIFO_AW = 4,
    parameter int OVF_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        br_addr,
    input  logic               addr_valid,
    input  logic               oe,
    input  logic               buserror,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [OVF_W-1:0]   ovf_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW+1)'(DEPTH);

`ifdef AUD_PKT_TIMESTAMP_EN
    localparam int   ENTRY_W = 51;
    localparam logic TS_BIT  = 1'b1;
`else
    localparam int   ENTRY_W = 35;
    localparam logic TS_BIT  = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, HDR, A0, A1, A2, A3, T0, T1} state_t;

    // ---------------- synchronisers ----------------
    logic oe_s1, oe_s2, oe_s3;
    logic be_s1, be_s2;
    logic push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_s1 <= 1'b0;
            oe_s2 <= 1'b0;
            oe_s3 <= 1'b0;
            be_s1 <= 1'b0;
            be_s2 <= 1'b0;
        end else begin
            oe_s1 <= oe;
            oe_s2 <= oe_s1;
            oe_s3 <= oe_s2;
            be_s1 <= buserror;
            be_s2 <= be_s1;
        end
    end

    assign push = oe_s2 & ~oe_s3;

`ifdef AUD_PKT_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 16'd1;
    end
`endif

    // ---------------- entry FIFO ----------------
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               lost_pending;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    logic               pop, wr_en, drop, full;

    assign full  = (level == LEVEL_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

`ifdef AUD_PKT_TIMESTAMP_EN
    assign wr_entry = {ts_cnt, lost_pending, be_s2, addr_valid, br_addr};
`else
    assign wr_entry = {lost_pending, be_s2, addr_valid, br_addr};
`endif
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            lost_pending <= 1'b0;
            ovf_cnt      <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + (FIFO_AW+1)'(1);
                2'b01:   level <= level - (FIFO_AW+1)'(1);
                default: level <= level;
            endcase
            if (drop) begin
                lost_pending <= 1'b1;
                if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + OVF_W'(1);
            end else if (wr_en) begin
                lost_pending <= 1'b0;
            end
        end
    end

    assign fifo_level = level;

    // ---------------- serializer ----------------
    state_t             state, next_state;
    logic [ENTRY_W-1:0] shreg;
    logic               frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            state <= next_state;
            if (pop) shreg <= rd_entry;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    next_state = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = {4'b1010, TS_BIT, shreg[33], shreg[34], shreg[32]};
                if (tx_ready) next_state = A0;
            end
            A0: begin
                tx_valid = 1'b1;
                tx_data  = shreg[7:0];
                if (tx_ready) next_state = A1;
            end
            A1: begin
                tx_valid = 1'b1;
                tx_data  = shreg[15:8];
                if (tx_ready) next_state = A2;
            end
            A2: begin
                tx_valid = 1'b1;
                tx_data  = shreg[23:16];
                if (tx_ready) next_state = A3;
            end
            A3: begin
                tx_valid = 1'b1;
                tx_data  = shreg[31:24];
`ifdef AUD_PKT_TIMESTAMP_EN
                if (tx_ready) next_state = T0;
`else
                if (tx_ready) frame_done = 1'b1;
`endif
            end
`ifdef AUD_PKT_TIMESTAMP_EN
            T0: begin
                tx_valid = 1'b1;
                tx_data  = shreg[42:35];
                if (tx_ready) next_state = T1;
            end
            T1: begin
                tx_valid = 1'b1;
                tx_data  = shreg[50:43];
                if (tx_ready) frame_done = 1'b1;
            end
`endif
            default: next_state = IDLE;
        endcase
        // Last byte accepted: reload straight into HDR when more entries wait.
        if (frame_done) begin
            if (level != '0) begin
                pop        = 1'b1;
                next_state = HDR;
            end else begin
                next_state = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_aud_trace_packer.sv
// Self-checking bench for aud_trace_packer: directed scenarios plus random traffic,
// checked every cycle against a queue-based frame model.
module tb_aud_trace_packer;

    localparam int FIFO_AW  = 2;
    localparam int OVF_W    = 3;
    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int OVF_MAX  = (1 << OVF_W) - 1;
`ifdef AUD_PKT_TIMESTAMP_EN
    localparam int         FL = 7;
    localparam logic [7:0] HT = 8'h08;
`else
    localparam int         FL = 5;
    localparam logic [7:0] HT = 8'h00;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       br_addr;
    logic              addr_valid, oe, buserror, tx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic [FIFO_AW:0]  fifo_level;
    logic [OVF_W-1:0]  ovf_cnt;

    always #5 clk = ~clk;

    aud_trace_packer #(.FIFO_AW(FIFO_AW), .OVF_W(OVF_W)) dut (
        .clk(clk), .rst(rst), .br_addr(br_addr), .addr_valid(addr_valid), .oe(oe),
        .buserror(buserror), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .ovf_cnt(ovf_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic        av, be, lost;
        logic [15:0] ts;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  cur[$];
    logic [7:0]  rx[$];
    logic        lost_p;
    int unsigned m_ovf;
    logic [15:0] m_ts;
    logic        oh0, oh1, oh2, bh0, bh1;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          rdy_mode = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete(); cur.delete();
        lost_p = 1'b0; m_ovf = 0; m_ts = '0;
        oh0 = 1'b0; oh1 = 1'b0; oh2 = 1'b0; bh0 = 1'b0; bh1 = 1'b0;
    endfunction

    function automatic void load_frame(ent_t e);
        cur.delete();
        cur.push_back(8'hA0 | HT | 8'({e.be, e.lost, e.av}));
        for (int unsigned i = 0; i < 4; i++) cur.push_back(e.addr[8*i +: 8]);
`ifdef AUD_PKT_TIMESTAMP_EN
        cur.push_back(e.ts[7:0]);
        cur.push_back(e.ts[15:8]);
`endif
    endfunction

    // One clock edge of the reference: oe rise becomes visible two edges later.
    function automatic void model_step();
        logic  push, acc, last_b, pop;
        ent_t  e;
        logic [7:0] dummy;
        push   = oh1 & ~oh2;
        acc    = (cur.size() != 0) && tx_ready;
        last_b = (cur.size() == 1);
        pop    = ((cur.size() == 0) || (acc && last_b)) && (q.size() != 0);
        if (acc) dummy = cur.pop_front();
        if (pop) begin
            e = q.pop_front();
            load_frame(e);
        end
        if (push) begin
            if (q.size() < DEPTH) begin
                e.addr = br_addr; e.av = addr_valid; e.be = bh1; e.lost = lost_p; e.ts = m_ts;
                q.push_back(e);
                lost_p = 1'b0;
            end else begin
                lost_p = 1'b1;
                if (m_ovf < OVF_MAX) m_ovf++;
            end
        end
        m_ts = m_ts + 16'd1;
        oh2 = oh1; oh1 = oh0; oh0 = oe;
        bh1 = bh0; bh0 = buserror;
    endfunction

    task automatic tick();
        cyc++;
        if (rdy_mode == 1)      tx_ready = (cyc % 3 == 0);
        else if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
        if (tx_valid && tx_ready) rx.push_back(tx_data);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        chk("tx_valid",   32'(tx_valid),   32'(cur.size() != 0));
        chk("tx_data",    32'(tx_data),    (cur.size() != 0) ? 32'(cur[0]) : 32'd0);
        chk("fifo_level", 32'(fifo_level), q.size());
        chk("ovf_cnt",    32'(ovf_cnt),    m_ovf);
    endtask

    task automatic strobe(logic [31:0] a, logic v, int gap);
        br_addr = a; addr_valid = v; oe = 1'b1;
        repeat (3) tick();
        oe = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            if (cur.size() == 0 && q.size() == 0) return;
            tick();
        end
        checks++; errors++;
        $error("FAIL drain_timeout observed=busy expected=idle");
    endtask

    task automatic check_frame(string tag, logic [31:0] a, logic [7:0] hdr);
        logic [7:0] exp_b[5];
        exp_b[0] = hdr; exp_b[1] = a[7:0]; exp_b[2] = a[15:8]; exp_b[3] = a[23:16]; exp_b[4] = a[31:24];
        chk({tag, "_len"}, rx.size(), FL);
        for (int i = 0; i < 5; i++)
            if (rx.size() > i) chk($sformatf("%s_b%0d", tag, i), 32'(rx[i]), 32'(exp_b[i]));
    endtask

    initial begin
        int n;
        logic [7:0] h;
        rst = 1'b1; oe = 1'b0; br_addr = '0; addr_valid = 1'b0; buserror = 1'b0; tx_ready = 1'b0;
        model_reset();
        repeat (2) tick();
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data",  32'(tx_data), 0);
        chk("rst_level",    32'(fifo_level), 0);
        chk("rst_ovf",      32'(ovf_cnt), 0);
        rst = 1'b0;
        repeat (2) tick();

        // single strobe, sink always ready
        tx_ready = 1'b1; rx.delete();
        strobe(32'h1234_5678, 1'b1, 4);
        drain();
        check_frame("single", 32'h1234_5678, 8'hA1 | HT);

        // backpressure 1-in-3
        rdy_mode = 1; rx.delete();
        strobe(32'h1234_5678, 1'b1, 4);
        drain();
        check_frame("bp", 32'h1234_5678, 8'hA1 | HT);
        rdy_mode = 0;

        // bus error level with addr_valid low
        tx_ready = 1'b1; buserror = 1'b1; rx.delete();
        repeat (4) tick();
        strobe(32'hDEAD_BEEF, 1'b0, 4);
        drain();
        check_frame("buserr", 32'hDEAD_BEEF, 8'hA4 | HT);
        buserror = 1'b0;
        repeat (4) tick();

        // overflow: one frame held in the serializer, DEPTH in the FIFO, the rest dropped
        tx_ready = 1'b0; rx.delete();
        for (int i = 0; i < 6; i++) strobe(32'h1000_0000 + 32'(i), 1'b1, 3);
        chk("ovf_level", 32'(fifo_level), DEPTH);
        chk("ovf_count", 32'(ovf_cnt), 1);
        for (int i = 0; i < 8; i++) strobe(32'h2000_0000 + 32'(i), 1'b1, 3);
        chk("ovf_sat", 32'(ovf_cnt), OVF_MAX);
        chk("ovf_level2", 32'(fifo_level), DEPTH);
        tx_ready = 1'b1;
        drain();
        strobe(32'h3000_0000, 1'b1, 4);
        drain();
        chk("ovf_frames", rx.size(), 6 * FL);
        for (int f = 0; f < 6; f++)
            if (rx.size() >= (f + 1) * FL) begin
                h = rx[f * FL];
                chk($sformatf("ovf_hdr_lost%0d", f), 32'(h[1]), 32'(f == 5));
            end

        // back-to-back: three queued frames stream without bubbles
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) strobe(32'hA5A5_0000 + 32'(i), 1'b1, 3);
        tx_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            if (tx_valid) n++;
            else if (n > 0) break;
            tick();
        end
        chk("b2b_run", n, 3 * FL);
        drain();

        // reset mid-frame after A1 accepted
        rx.delete();
        br_addr = 32'hCAFE_F00D; addr_valid = 1'b1; oe = 1'b1;
        for (int i = 0; i < 40 && rx.size() < 3; i++) begin
            if (i == 3) oe = 1'b0;
            tick();
        end
        oe = 1'b0;
        chk("mid_bytes", rx.size(), 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_ovf",   32'(ovf_cnt), 0);
        model_reset(); rx.delete();
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_idle", 32'(tx_valid), 0);
        strobe(32'h0BAD_C0DE, 1'b1, 4);
        drain();
        check_frame("fresh", 32'h0BAD_C0DE, 8'hA1 | HT);

        // random traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 30; i++) begin
            buserror = 1'($urandom_range(0, 1));
            strobe($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(3, 9)));
        end
        rdy_mode = 0; tx_ready = 1'b1;
        drain();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
